// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for the 8-bit RISC CPU.
// Ports: clk/rst, ins, mem_rdy, irq in; datapath strobes, fetch, irq_ack, fault, depth, state out.
module cpu_sequencer #(
    parameter int INS_W      = 4,
    parameter int CALL_DEPTH = 4,
    parameter int WAIT_EN    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [INS_W-1:0]                  ins,
    input  logic                              mem_rdy,
    input  logic                              irq,
    output logic                              write_r,
    output logic                              read_r,
    output logic                              PC_en,
    output logic                              PC_wr,
    output logic                              acall,
    output logic                              ac_ena,
    output logic                              ram_ena,
    output logic                              rom_ena,
    output logic                              ram_write,
    output logic                              ram_read,
    output logic                              rom_read,
    output logic                              ad_sel,
    output logic [1:0]                        fetch,
    output logic                              irq_ack,
    output logic                              fault,
    output logic [$clog2(CALL_DEPTH+1)-1:0]   depth,
    output logic [3:0]                        state
);

    localparam int DW = $clog2(CALL_DEPTH + 1);
    localparam logic [DW-1:0] MAX_D = DW'(CALL_DEPTH);

    localparam logic [3:0] S_IDLE   = 4'hF;
    localparam logic [3:0] S_FETCH  = 4'h0;
    localparam logic [3:0] S_DECODE = 4'h1;
    localparam logic [3:0] S_HALT   = 4'h2;
    localparam logic [3:0] S_ADR1   = 4'h3;
    localparam logic [3:0] S_ADR2   = 4'h4;
    localparam logic [3:0] S_LOAD   = 4'h5;
    localparam logic [3:0] S_BRANCH = 4'h6;
    localparam logic [3:0] S_ST1    = 4'h7;
    localparam logic [3:0] S_ST2    = 4'h8;
    localparam logic [3:0] S_ALU1   = 4'h9;
    localparam logic [3:0] S_ALU2   = 4'hA;
    localparam logic [3:0] S_LDM    = 4'hB;
    localparam logic [3:0] S_IRQ    = 4'hC;
    localparam logic [3:0] S_FAULT  = 4'hD;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h2;
    localparam logic [3:0] OP_STO  = 4'h3;
    localparam logic [3:0] OP_PRE  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_LAND = 4'h8;
    localparam logic [3:0] OP_LOR  = 4'h9;
    localparam logic [3:0] OP_LNOT = 4'hA;
    localparam logic [3:0] OP_INC  = 4'hB;
    localparam logic [3:0] OP_ACL  = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hD;
    localparam logic [3:0] OP_LDM  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    logic [3:0] op;
    logic [3:0] nxt;
    logic [3:0] bnd;
    logic       illegal;
    logic       rdy;
    logic       irq_take;
    logic       is_alu;

    assign op = ins[3:0];

    generate
        if (INS_W > 4) begin : g_hi
            assign illegal = |ins[INS_W-1:4];
        end else begin : g_no_hi
            assign illegal = 1'b0;
        end
    endgenerate

    assign rdy      = (WAIT_EN == 0) || mem_rdy;
    assign irq_take = irq && (depth < MAX_D);
    // Instruction boundary: an interrupt is only taken here or in HALT.
    assign bnd      = irq_take ? S_IRQ : S_FETCH;
    assign is_alu   = (op == OP_PRE) || (op == OP_ADD) ||
                      (op == OP_SUB) || (op == OP_LAND) ||
                      (op == OP_LOR) || (op == OP_LNOT) ||
                      (op == OP_INC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            depth <= '0;
        end else begin
            state <= nxt;
            if (state == S_IRQ ||
                (state == S_BRANCH && op == OP_ACL))
                depth <= depth + 1'b1;
            else if (state == S_BRANCH && op == OP_RET)
                depth <= depth - 1'b1;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH:  nxt = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (illegal)                              nxt = S_FAULT;
                else if (op == OP_NOP)                    nxt = bnd;
                else if (op == OP_HLT)                    nxt = S_HALT;
                else if (is_alu)                          nxt = S_ALU1;
                else if (op == OP_LDM)                    nxt = S_LDM;
                else if (op == OP_ACL && depth == MAX_D)  nxt = S_FAULT;
                else if (op == OP_RET && depth == '0)     nxt = S_FAULT;
                else if (op == OP_JMP || op == OP_ACL ||
                         op == OP_RET)                    nxt = S_BRANCH;
                else                                      nxt = S_ADR1;
            end
            S_ADR1:   nxt = S_ADR2;
            S_ADR2:   nxt = (op == OP_STO) ? S_ST1 : S_LOAD;
            S_LOAD:   nxt = rdy ? S_HALT : S_LOAD;
            S_BRANCH: nxt = S_HALT;
            S_LDM:    nxt = S_HALT;
            S_ST1:    nxt = S_ST2;
            S_ST2:    nxt = rdy ? bnd : S_ST2;
            S_ALU1:   nxt = S_ALU2;
            S_ALU2:   nxt = bnd;
            S_HALT: begin
                if (irq_take)                       nxt = S_IRQ;
                else if (ins == INS_W'(OP_HLT))     nxt = S_HALT;
                else                                nxt = S_FETCH;
            end
            S_IRQ:    nxt = S_FETCH;
            S_FAULT:  nxt = S_FAULT;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        write_r   = 1'b0;
        read_r    = 1'b0;
        PC_en     = 1'b0;
        PC_wr     = 1'b0;
        acall     = 1'b0;
        ac_ena    = 1'b0;
        ram_ena   = 1'b0;
        rom_ena   = 1'b0;
        ram_write = 1'b0;
        ram_read  = 1'b0;
        rom_read  = 1'b0;
        ad_sel    = 1'b0;
        fetch     = 2'b00;
        irq_ack   = 1'b0;
        fault     = 1'b0;
        case (state)
            S_FETCH: begin
                rom_ena  = 1'b1;
                rom_read = 1'b1;
                fetch    = 2'b01;
            end
            S_DECODE: begin
                PC_en    = 1'b1;
                rom_ena  = 1'b1;
                rom_read = 1'b1;
            end
            S_ADR1, S_ADR2: begin
                ac_ena   = 1'b1;
                rom_ena  = 1'b1;
                rom_read = 1'b1;
                fetch    = 2'b10;
                PC_en    = (state == S_ADR2);
            end
            S_LOAD: begin
                write_r = 1'b1;
                ac_ena  = 1'b1;
                ad_sel  = 1'b1;
                fetch   = 2'b01;
                if (op == OP_LDA) begin
                    ram_ena  = 1'b1;
                    ram_read = 1'b1;
                end else begin
                    rom_ena  = 1'b1;
                    rom_read = 1'b1;
                end
            end
            S_BRANCH: begin
                if (op == OP_RET) begin
                    acall = 1'b1;
                end else begin
                    ac_ena   = 1'b1;
                    rom_ena  = 1'b1;
                    rom_read = 1'b1;
                    PC_wr    = 1'b1;
                    acall    = (op == OP_ACL);
                end
            end
            S_ST1: read_r = 1'b1;
            S_ST2: begin
                read_r    = 1'b1;
                ram_ena   = 1'b1;
                ram_write = 1'b1;
                ad_sel    = 1'b1;
            end
            S_ALU1: begin
                ac_ena = 1'b1;
                read_r = !(op == OP_LNOT || op == OP_INC);
            end
            S_ALU2: read_r = 1'b1;
            S_LDM: begin
                write_r  = 1'b1;
                ac_ena   = 1'b1;
                rom_ena  = 1'b1;
                rom_read = 1'b1;
            end
            S_IRQ: begin
                PC_wr   = 1'b1;
                acall   = 1'b1;
                irq_ack = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: vector-table bench for cpu_sequencer.
// Two instances: wide/shallow with wait states, default width without wait states.
module tb_cpu_sequencer;

    localparam bit [15:0] WR  = 16'h8000;
    localparam bit [15:0] RR  = 16'h4000;
    localparam bit [15:0] PCE = 16'h2000;
    localparam bit [15:0] PCW = 16'h1000;
    localparam bit [15:0] ACA = 16'h0800;
    localparam bit [15:0] ACE = 16'h0400;
    localparam bit [15:0] RAE = 16'h0200;
    localparam bit [15:0] ROE = 16'h0100;
    localparam bit [15:0] RAW = 16'h0080;
    localparam bit [15:0] RAR = 16'h0040;
    localparam bit [15:0] ROR = 16'h0020;
    localparam bit [15:0] ADS = 16'h0010;
    localparam bit [15:0] F10 = 16'h0008;
    localparam bit [15:0] F01 = 16'h0004;
    localparam bit [15:0] IAK = 16'h0002;
    localparam bit [15:0] FLT = 16'h0001;

    localparam bit [15:0] O_NON = 16'h0000;
    localparam bit [15:0] O_FET = ROE | ROR | F01;
    localparam bit [15:0] O_DEC = PCE | ROE | ROR;
    localparam bit [15:0] O_AD1 = ACE | ROE | ROR | F10;
    localparam bit [15:0] O_AD2 = ACE | ROE | ROR | F10 | PCE;
    localparam bit [15:0] O_LDO = WR | ACE | ROE | ROR | ADS | F01;
    localparam bit [15:0] O_LDA = WR | ACE | RAE | RAR | ADS | F01;
    localparam bit [15:0] O_JMP = ACE | ROE | ROR | PCW;
    localparam bit [15:0] O_ACL = ACE | ROE | ROR | PCW | ACA;
    localparam bit [15:0] O_RET = ACA;
    localparam bit [15:0] O_ST1 = RR;
    localparam bit [15:0] O_ST2 = RR | RAE | RAW | ADS;
    localparam bit [15:0] O_AL1 = ACE | RR;
    localparam bit [15:0] O_ALN = ACE;
    localparam bit [15:0] O_AL2 = RR;
    localparam bit [15:0] O_LDM = WR | ACE | ROE | ROR;
    localparam bit [15:0] O_IRQ = PCW | ACA | IAK;
    localparam bit [15:0] O_FLT = FLT;

    typedef struct {
        bit        sel;
        bit        rst;
        bit [5:0]  ins;
        bit        rdy;
        bit        irq;
        bit [3:0]  st;
        bit [15:0] out;
        bit [2:0]  d;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_rdy, a_irq;
    logic [5:0] a_ins;
    logic       a_write_r, a_read_r, a_PC_en, a_PC_wr, a_acall, a_ac_ena;
    logic       a_ram_ena, a_rom_ena, a_ram_write, a_ram_read, a_rom_read, a_ad_sel;
    logic [1:0] a_fetch;
    logic       a_irq_ack, a_fault;
    logic [1:0] a_depth;
    logic [3:0] a_state;

    logic       b_rst, b_rdy, b_irq;
    logic [3:0] b_ins;
    logic       b_write_r, b_read_r, b_PC_en, b_PC_wr, b_acall, b_ac_ena;
    logic       b_ram_ena, b_rom_ena, b_ram_write, b_ram_read, b_rom_read, b_ad_sel;
    logic [1:0] b_fetch;
    logic       b_irq_ack, b_fault;
    logic [2:0] b_depth;
    logic [3:0] b_state;

    cpu_sequencer #(.INS_W(6), .CALL_DEPTH(2), .WAIT_EN(1)) dut_a (
        .clk(clk), .rst(a_rst), .ins(a_ins), .mem_rdy(a_rdy), .irq(a_irq),
        .write_r(a_write_r), .read_r(a_read_r), .PC_en(a_PC_en),
        .PC_wr(a_PC_wr), .acall(a_acall), .ac_ena(a_ac_ena),
        .ram_ena(a_ram_ena), .rom_ena(a_rom_ena), .ram_write(a_ram_write),
        .ram_read(a_ram_read), .rom_read(a_rom_read), .ad_sel(a_ad_sel),
        .fetch(a_fetch), .irq_ack(a_irq_ack), .fault(a_fault),
        .depth(a_depth), .state(a_state)
    );

    cpu_sequencer #(.INS_W(4), .CALL_DEPTH(4), .WAIT_EN(0)) dut_b (
        .clk(clk), .rst(b_rst), .ins(b_ins), .mem_rdy(b_rdy), .irq(b_irq),
        .write_r(b_write_r), .read_r(b_read_r), .PC_en(b_PC_en),
        .PC_wr(b_PC_wr), .acall(b_acall), .ac_ena(b_ac_ena),
        .ram_ena(b_ram_ena), .rom_ena(b_rom_ena), .ram_write(b_ram_write),
        .ram_read(b_ram_read), .rom_read(b_rom_read), .ad_sel(b_ad_sel),
        .fetch(b_fetch), .irq_ack(b_irq_ack), .fault(b_fault),
        .depth(b_depth), .state(b_state)
    );

    logic [15:0] a_o, b_o;
    assign a_o = {a_write_r, a_read_r, a_PC_en, a_PC_wr, a_acall, a_ac_ena,
                  a_ram_ena, a_rom_ena, a_ram_write, a_ram_read, a_rom_read,
                  a_ad_sel, a_fetch, a_irq_ack, a_fault};
    assign b_o = {b_write_r, b_read_r, b_PC_en, b_PC_wr, b_acall, b_ac_ena,
                  b_ram_ena, b_rom_ena, b_ram_write, b_ram_read, b_rom_read,
                  b_ad_sel, b_fetch, b_irq_ack, b_fault};

    int   checks = 0;
    int   fails  = 0;
    vec_t vec[$];
    vec_t exp_q[$];

    task automatic chk(input string nm, input int idx,
                       input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s vec=%0d got=%h want=%h", nm, idx, act, req);
        end
    endtask

    task automatic add(input bit s, input bit r, input bit [5:0] i,
                       input bit m, input bit q, input bit [3:0] st,
                       input bit [15:0] o, input bit [2:0] d);
        vec_t t;
        t.sel = s; t.rst = r; t.ins = i; t.rdy = m; t.irq = q;
        t.st = st; t.out = o; t.d = d;
        vec.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        if (!t.sel) begin
            a_rst = t.rst; a_ins = t.ins; a_rdy = t.rdy; a_irq = t.irq;
            b_rst = 1'b1;
        end else begin
            b_rst = t.rst; b_ins = t.ins[3:0]; b_rdy = t.rdy; b_irq = t.irq;
            a_rst = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        int   acks;
        // NOP loop
        add(0,0,6'h00,1,0,4'hF,O_NON,0);
        add(0,0,6'h00,1,0,4'h0,O_FET,0);
        add(0,0,6'h00,1,0,4'h1,O_DEC,0);
        add(0,0,6'h00,1,0,4'h0,O_FET,0);
        add(0,0,6'h00,1,0,4'h1,O_DEC,0);
        // STO with two ST2 stalls
        add(0,0,6'h03,1,0,4'h0,O_FET,0);
        add(0,0,6'h03,1,0,4'h1,O_DEC,0);
        add(0,0,6'h03,1,0,4'h3,O_AD1,0);
        add(0,0,6'h03,1,0,4'h4,O_AD2,0);
        add(0,0,6'h03,1,0,4'h7,O_ST1,0);
        add(0,0,6'h03,0,0,4'h8,O_ST2,0);
        add(0,0,6'h03,0,0,4'h8,O_ST2,0);
        add(0,0,6'h03,1,0,4'h8,O_ST2,0);
        // ACL x3 at CALL_DEPTH=2, FETCH stall first
        add(0,0,6'h0C,0,0,4'h0,O_FET,0);
        add(0,0,6'h0C,1,0,4'h0,O_FET,0);
        add(0,0,6'h0C,1,0,4'h1,O_DEC,0);
        add(0,0,6'h0C,1,0,4'h6,O_ACL,0);
        add(0,0,6'h0C,1,0,4'h2,O_NON,1);
        add(0,0,6'h0C,1,0,4'h0,O_FET,1);
        add(0,0,6'h0C,1,0,4'h1,O_DEC,1);
        add(0,0,6'h0C,1,0,4'h6,O_ACL,1);
        add(0,0,6'h0C,1,0,4'h2,O_NON,2);
        add(0,0,6'h0C,1,0,4'h0,O_FET,2);
        add(0,0,6'h0C,1,0,4'h1,O_DEC,2);
        add(0,0,6'h0C,1,0,4'hD,O_FLT,2);
        add(0,0,6'h00,1,0,4'hD,O_FLT,2);
        add(0,1,6'h00,1,0,4'hD,O_FLT,2);
        add(0,0,6'h00,1,0,4'hF,O_NON,0);
        // RET at depth 0
        add(0,0,6'h0D,1,0,4'h0,O_FET,0);
        add(0,0,6'h0D,1,0,4'h1,O_DEC,0);
        add(0,0,6'h0D,1,0,4'hD,O_FLT,0);
        add(0,1,6'h0D,1,0,4'hD,O_FLT,0);
        add(0,0,6'h0D,1,0,4'hF,O_NON,0);
        // illegal upper bits
        add(0,0,6'h16,1,0,4'h0,O_FET,0);
        add(0,0,6'h16,1,0,4'h1,O_DEC,0);
        add(0,0,6'h16,1,0,4'hD,O_FLT,0);
        add(0,1,6'h16,1,0,4'hD,O_FLT,0);
        add(0,0,6'h0F,1,0,4'hF,O_NON,0);
        // HLT, then irq
        add(0,0,6'h0F,1,0,4'h0,O_FET,0);
        add(0,0,6'h0F,1,0,4'h1,O_DEC,0);
        add(0,0,6'h0F,1,0,4'h2,O_NON,0);
        add(0,0,6'h0F,1,0,4'h2,O_NON,0);
        add(0,0,6'h0F,1,1,4'h2,O_NON,0);
        add(0,0,6'h0F,1,0,4'hC,O_IRQ,0);
        // LDO with LOAD stall, irq in HALT
        add(0,0,6'h01,1,0,4'h0,O_FET,1);
        add(0,0,6'h01,1,0,4'h1,O_DEC,1);
        add(0,0,6'h01,1,0,4'h3,O_AD1,1);
        add(0,0,6'h01,1,0,4'h4,O_AD2,1);
        add(0,0,6'h01,0,0,4'h5,O_LDO,1);
        add(0,0,6'h01,1,0,4'h5,O_LDO,1);
        add(0,0,6'h01,1,1,4'h2,O_NON,1);
        add(0,0,6'h01,1,1,4'hC,O_IRQ,1);
        // ADD with irq held at full depth: not taken, no fault
        add(0,0,6'h06,1,1,4'h0,O_FET,2);
        add(0,0,6'h06,1,1,4'h1,O_DEC,2);
        add(0,0,6'h06,1,1,4'h9,O_AL1,2);
        add(0,0,6'h06,1,1,4'hA,O_AL2,2);
        // RET from depth 2
        add(0,0,6'h0D,1,0,4'h0,O_FET,2);
        add(0,0,6'h0D,1,0,4'h1,O_DEC,2);
        add(0,0,6'h0D,1,0,4'h6,O_RET,2);
        add(0,0,6'h0D,1,0,4'h2,O_NON,1);
        // LDM
        add(0,0,6'h0E,1,0,4'h0,O_FET,1);
        add(0,0,6'h0E,1,0,4'h1,O_DEC,1);
        add(0,0,6'h0E,1,0,4'hB,O_LDM,1);
        add(0,0,6'h0E,1,0,4'h2,O_NON,1);
        // LNOT
        add(0,0,6'h0A,1,0,4'h0,O_FET,1);
        add(0,0,6'h0A,1,0,4'h1,O_DEC,1);
        add(0,0,6'h0A,1,0,4'h9,O_ALN,1);
        add(0,0,6'h0A,1,0,4'hA,O_AL2,1);
        // JMP
        add(0,0,6'h05,1,0,4'h0,O_FET,1);
        add(0,0,6'h05,1,0,4'h1,O_DEC,1);
        add(0,0,6'h05,1,0,4'h6,O_JMP,1);
        add(0,0,6'h05,1,0,4'h2,O_NON,1);
        // LDA, then reset mid-instruction
        add(0,0,6'h02,1,0,4'h0,O_FET,1);
        add(0,0,6'h02,1,0,4'h1,O_DEC,1);
        add(0,0,6'h02,1,0,4'h3,O_AD1,1);
        add(0,0,6'h02,1,0,4'h4,O_AD2,1);
        add(0,0,6'h02,1,0,4'h5,O_LDA,1);
        add(0,0,6'h02,1,0,4'h2,O_NON,1);
        add(0,1,6'h02,1,0,4'h0,O_FET,1);
        add(0,0,6'h02,1,0,4'hF,O_NON,0);
        // dut_b: WAIT_EN=0, mem_rdy low throughout
        add(1,0,6'h02,0,0,4'hF,O_NON,0);
        add(1,0,6'h02,0,0,4'h0,O_FET,0);
        add(1,0,6'h02,0,0,4'h1,O_DEC,0);
        add(1,0,6'h02,0,0,4'h3,O_AD1,0);
        add(1,0,6'h02,0,0,4'h4,O_AD2,0);
        add(1,0,6'h02,0,0,4'h5,O_LDA,0);
        add(1,0,6'h02,0,0,4'h2,O_NON,0);
        add(1,0,6'h03,0,0,4'h0,O_FET,0);
        add(1,0,6'h03,0,0,4'h1,O_DEC,0);
        add(1,0,6'h03,0,0,4'h3,O_AD1,0);
        add(1,0,6'h03,0,0,4'h4,O_AD2,0);
        add(1,0,6'h03,0,0,4'h7,O_ST1,0);
        add(1,0,6'h03,0,0,4'h8,O_ST2,0);
        // NOP boundary takes irq
        add(1,0,6'h00,0,1,4'h0,O_FET,0);
        add(1,0,6'h00,0,1,4'h1,O_DEC,0);
        add(1,0,6'h00,0,0,4'hC,O_IRQ,0);
        add(1,0,6'h0B,0,0,4'h0,O_FET,1);
        add(1,0,6'h0B,0,0,4'h1,O_DEC,1);
        add(1,0,6'h0B,0,0,4'h9,O_ALN,1);
        add(1,0,6'h0B,0,0,4'hA,O_AL2,1);

        a_rst = 1'b1; a_ins = '0; a_rdy = 1'b1; a_irq = 1'b0;
        b_rst = 1'b1; b_ins = '0; b_rdy = 1'b1; b_irq = 1'b0;
        repeat (2) @(posedge clk);

        for (int k = 0; k < vec.size(); k++) begin
            @(negedge clk);
            drive(vec[k]);
            exp_q.push_back(vec[k]);
            #2;
            e = exp_q.pop_front();
            if (!e.sel) begin
                chk("state", k, {12'd0, a_state}, {12'd0, e.st});
                chk("strobes", k, a_o, e.out);
                chk("depth", k, {14'd0, a_depth}, {13'd0, e.d});
            end else begin
                chk("state", k, {12'd0, b_state}, {12'd0, e.st});
                chk("strobes", k, b_o, e.out);
                chk("depth", k, {13'd0, b_depth}, {13'd0, e.d});
            end
        end

        // Held HLT, irq raised until acknowledged: exactly one ack pulse.
        @(negedge clk);
        a_rst = 1'b1; a_ins = 6'h0F; a_rdy = 1'b1; a_irq = 1'b0;
        @(negedge clk);
        a_rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("hlt_hold", 0, {12'd0, a_state}, 16'h0002);
        a_irq = 1'b1;
        acks  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (a_irq_ack) begin
                acks++;
                a_irq = 1'b0;
            end
        end
        chk("ack_count", 0, 16'(acks), 16'd1);
        chk("ack_depth", 0, {14'd0, a_depth}, 16'd1);
        chk("ack_state", 0, {12'd0, a_state}, 16'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
